// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal branch predictor with direct-mapped BTB
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = XLEN - INDEX_BITS - 2;

  // Table storage, one slot per index
  logic              entry_valid  [ENTRIES];
  logic [TAG_W-1:0]  entry_tag    [ENTRIES];
  logic [XLEN-1:0]   entry_target [ENTRIES];
  logic [1:0]        entry_ctr    [ENTRIES];

  logic [INDEX_BITS-1:0] pred_idx;
  logic [TAG_W-1:0]      pred_tag;
  logic                  pred_hit;
  logic [XLEN-1:0]       pred_seq;

  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]      upd_tag;
  logic                  upd_hit;
  logic [1:0]            upd_ctr;
  logic [1:0]            ctr_up;
  logic [1:0]            ctr_down;
  logic [XLEN-1:0]       correct_pc;

  assign pred_idx = pred_pc[INDEX_BITS+1:2];
  assign pred_tag = pred_pc[XLEN-1:INDEX_BITS+2];
  assign upd_idx  = upd_pc[INDEX_BITS+1:2];
  assign upd_tag  = upd_pc[XLEN-1:INDEX_BITS+2];

  // Fetch-side lookup: reads the table as it stands before this cycle's update
  always_comb begin
    pred_hit    = entry_valid[pred_idx] && (entry_tag[pred_idx] == pred_tag);
    pred_seq    = pred_pc + XLEN'(4);
    pred_taken  = pred_hit && entry_ctr[pred_idx][1];
    pred_target = pred_taken ? entry_target[pred_idx] : pred_seq;
  end

  // Execute-side resolution; redirect is held low while reset is asserted
  always_comb begin
    correct_pc     = upd_taken ? upd_target : (upd_pc + XLEN'(4));
    redirect_valid = rst_n && upd_valid &&
                     ((upd_pred_taken != upd_taken) || (upd_pred_target != correct_pc));
    redirect_pc    = correct_pc;
  end

  // Saturating next-counter values for the entry being trained
  always_comb begin
    upd_hit  = entry_valid[upd_idx] && (entry_tag[upd_idx] == upd_tag);
    upd_ctr  = entry_ctr[upd_idx];
    ctr_up   = (upd_ctr == 2'b11) ? upd_ctr : upd_ctr + 2'd1;
    ctr_down = (upd_ctr == 2'b00) ? upd_ctr : upd_ctr - 2'd1;
  end

  // Table training: strengthen/weaken on hit, allocate only on a taken miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_valid[i]  <= 1'b0;
        entry_tag[i]    <= '0;
        entry_target[i] <= '0;
        entry_ctr[i]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          entry_ctr[upd_idx]    <= ctr_up;
          entry_target[upd_idx] <= upd_target;
        end else begin
          entry_ctr[upd_idx] <= ctr_down;
        end
      end else if (upd_taken) begin
        entry_valid[upd_idx]  <= 1'b1;
        entry_tag[upd_idx]    <= upd_tag;
        entry_target[upd_idx] <= upd_target;
        entry_ctr[upd_idx]    <= 2'b10;
      end
    end
  end

  // Statistics: every resolved branch, and every one that forced a redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd_valid) begin
      stat_branches <= stat_branches + 32'd1;
      if (redirect_valid) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_predictor #(.INDEX_BITS(6), .XLEN(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pred_pc         (pred_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one record per table slot, counter as a plain integer 0..3
  bit          m_valid  [64];
  int unsigned m_tag    [64];
  int unsigned m_target [64];
  int          m_ctr    [64];
  int unsigned m_branches;
  int unsigned m_misp;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    m_branches = 0;
    m_misp = 0;
  endtask

  task automatic model_lookup(input int unsigned pc, output bit t, output int unsigned tgt);
    int unsigned idx;
    idx = (pc / 4) % 64;
    t   = m_valid[idx] && (m_tag[idx] == pc / 256) && (m_ctr[idx] >= 2);
    tgt = t ? m_target[idx] : pc + 4;
  endtask

  task automatic model_train(input int unsigned pc, input bit taken, input int unsigned tgt);
    int unsigned idx;
    idx = (pc / 4) % 64;
    if (m_valid[idx] && m_tag[idx] == pc / 256) begin
      if (taken) begin
        m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
        m_target[idx] = tgt;
      end else begin
        m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[idx] = 1'b1; m_tag[idx] = pc / 256; m_target[idx] = tgt; m_ctr[idx] = 2;
    end
  endtask

  // One cycle: lookup + optional update, compared against the model before and after the edge
  task automatic apply(input logic [31:0] p_pc, input bit uv, input logic [31:0] u_pc,
                       input bit ut, input logic [31:0] u_tgt, input bit upt,
                       input logic [31:0] u_ptgt);
    bit          e_t;
    int unsigned e_tgt;
    int unsigned e_cpc;
    bit          e_redir;
    @(negedge clk);
    pred_pc = p_pc; upd_valid = uv; upd_pc = u_pc; upd_taken = ut;
    upd_target = u_tgt; upd_pred_taken = upd_pred_taken_sel(upt); upd_pred_target = u_ptgt;
    #1;
    model_lookup(p_pc, e_t, e_tgt);
    e_cpc   = ut ? u_tgt : u_pc + 4;
    e_redir = uv && ((upt != ut) || (u_ptgt != e_cpc));
    check_value("pred_taken", {31'd0, pred_taken}, {31'd0, e_t});
    check_value("pred_target", pred_target, e_tgt);
    check_value("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_redir});
    check_value("redirect_pc", redirect_pc, e_cpc);
    @(posedge clk);
    if (uv) begin
      m_branches++;
      if (e_redir) m_misp++;
      model_train(u_pc, ut, u_tgt);
    end
    #1;
    check_value("stat_branches", stat_branches, m_branches);
    check_value("stat_mispredicts", stat_mispredicts, m_misp);
  endtask

  function automatic logic upd_pred_taken_sel(input bit b);
    return b;
  endfunction

  // Lookup only, against fixed expectations taken from the scenario
  task automatic lookup_expect(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
    @(negedge clk);
    pred_pc = pc; upd_valid = 1'b0;
    #1;
    check_value("look_taken", {31'd0, pred_taken}, {31'd0, t});
    check_value("look_target", pred_target, tgt);
    check_value("look_redirect", {31'd0, redirect_valid}, 32'd0);
    check_value("look_branches", stat_branches, m_branches);
    check_value("look_misp", stat_mispredicts, m_misp);
  endtask

  function automatic logic [31:0] pick_pc();
    int unsigned t;
    logic [31:0] tg;
    logic [31:0] ix;
    logic [31:0] lo;
    t  = $urandom_range(0, 3);
    tg = (t == 3) ? 32'h00FF_FFFF : t;
    ix = $urandom_range(0, 7);
    lo = $urandom_range(0, 3);
    return (tg << 8) | (ix << 2) | lo;
  endfunction

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] ppc;
      logic [31:0] upc;
      logic [31:0] utgt;
      logic [31:0] ptgt;
      bit          ut;
      bit          upt;
      bit          mt;
      int unsigned mtgt;
      upc  = pick_pc();
      ppc  = ($urandom_range(0, 3) == 0) ? upc : pick_pc();
      ut   = $urandom_range(0, 1);
      utgt = $urandom_range(0, 3) == 0 ? pick_pc() : (32'h1000 + ($urandom_range(0, 3) << 2));
      model_lookup(upc, mt, mtgt);
      if ($urandom_range(0, 1) == 1) begin
        upt = mt; ptgt = mtgt;
      end else begin
        upt = $urandom_range(0, 1); ptgt = upt ? utgt : upc + 32'd4;
      end
      apply(ppc, $urandom_range(0, 4) != 0, upc, ut, utgt, upt, ptgt);
    end
  endtask

  initial begin
    rst_n = 1'b0; pred_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    model_reset();
    #1;
    check_value("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check_value("rst_pred_target", pred_target, 32'h104);
    check_value("rst_branches", stat_branches, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    lookup_expect(32'h100, 1'b0, 32'h104);
    // First taken resolution is a mispredict and allocates the entry
    apply(32'h100, 1, 32'h100, 1, 32'h40, 0, 32'h104);
    check_value("plan_misp", stat_mispredicts, 32'd1);
    lookup_expect(32'h100, 1'b1, 32'h40);
    // Saturation up then down through 00
    repeat (3) apply(32'h100, 1, 32'h100, 1, 32'h40, 1, 32'h40);
    apply(32'h100, 1, 32'h100, 0, 32'h40, 1, 32'h40);
    lookup_expect(32'h100, 1'b1, 32'h40);
    apply(32'h100, 1, 32'h100, 0, 32'h40, 1, 32'h40);
    lookup_expect(32'h100, 1'b0, 32'h104);
    apply(32'h100, 1, 32'h100, 0, 32'h40, 0, 32'h104);
    apply(32'h100, 1, 32'h100, 0, 32'h40, 0, 32'h104);
    apply(32'h100, 1, 32'h100, 1, 32'h40, 0, 32'h104);
    lookup_expect(32'h100, 1'b0, 32'h104);
    apply(32'h100, 1, 32'h100, 1, 32'h40, 0, 32'h104);
    lookup_expect(32'h100, 1'b1, 32'h40);
    // Alias at the same index replaces the entry
    apply(32'h200, 1, 32'h200, 1, 32'h80, 0, 32'h204);
    lookup_expect(32'h100, 1'b0, 32'h104);
    lookup_expect(32'h200, 1'b1, 32'h80);
    // Correct prediction, then wrong target only
    apply(32'h300, 1, 32'h300, 1, 32'h40, 1, 32'h40);
    apply(32'h300, 1, 32'h300, 1, 32'h40, 1, 32'h44);
    // Sequential-PC wrap at the top of the address space
    lookup_expect(32'hFFFF_FFFC, 1'b0, 32'h0);

    random_cycles(400);

    // Retrain 0x100, then assert reset between edges mid-update
    apply(32'h100, 1, 32'h100, 1, 32'h40, 0, 32'h104);
    apply(32'h100, 1, 32'h100, 1, 32'h40, 0, 32'h104);
    lookup_expect(32'h100, 1'b1, 32'h40);
    @(negedge clk);
    pred_pc = 32'h100; upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
    upd_target = 32'h40; upd_pred_taken = 1'b0; upd_pred_target = 32'h104;
    #2 rst_n = 1'b0;
    #1;
    check_value("arst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check_value("arst_pred_target", pred_target, 32'h104);
    check_value("arst_redirect", {31'd0, redirect_valid}, 32'd0);
    check_value("arst_branches", stat_branches, 32'd0);
    check_value("arst_misp", stat_mispredicts, 32'd0);
    model_reset();
    @(negedge clk);
    upd_valid = 1'b0;
    rst_n = 1'b1;
    lookup_expect(32'h100, 1'b0, 32'h104);

    random_cycles(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Bimodal branch predictor with a direct-mapped branch target buffer (BTB).
- Fetch side: gives a same-cycle taken/target prediction for the fetch PC.
- Execute side: consumes the resolved outcome from the branch condition evaluator (taken flag plus computed target), trains the tables, and raises a redirect on misprediction.
- Also holds branch and mispredict statistics counters.

Parameters:
- INDEX_BITS, 6, log2 of BTB/counter entries (64 entries).
- XLEN, 32, PC/target width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pred_pc  in  XLEN  fetch-stage PC to predict.
- pred_taken  out  1  prediction: branch taken.
- pred_target  out  XLEN  predicted next PC.
- upd_valid  in  1  a conditional branch/jump resolved this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  actual outcome (is_branch_jump from the condition evaluator).
- upd_target  in  XLEN  actual taken target computed in execute.
- upd_pred_taken  in  1  prediction carried down the pipe for this instruction.
- upd_pred_target  in  XLEN  predicted next PC carried down the pipe.
- redirect_valid  out  1  mispredict: fetch must restart.
- redirect_pc  out  XLEN  correct next PC.
- stat_branches  out  32  resolved branch count.
- stat_mispredicts  out  32  mispredict count.

Behaviour:
- Entry layout: valid (1), tag (XLEN-INDEX_BITS-2), target (XLEN), ctr (2-bit saturating).
- Index = pc[INDEX_BITS+1:2]. Tag = pc[XLEN-1:INDEX_BITS+2]. pc[1:0] is ignored.
- Reset (async, rst_n=0):
  - all valid=0; all ctr=2'b01 (weakly not-taken).
  - stat_branches=0, stat_mispredicts=0.
  - While in reset: redirect_valid=0, pred_taken=0, pred_target=pred_pc+4.
  - Reset mid-operation discards all learned state immediately.
- Lookup (combinational, 0-cycle latency):
  - hit = valid[idx] && tag[idx]==tag(pred_pc).
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : pred_pc+4 (mod 2^XLEN; 0xFFFFFFFC wraps to 0x0).
- Update (registered, effective at the next rising edge, only when upd_valid=1):
  - Hit on upd_pc, upd_taken=1: ctr saturating increment, max 2'b11; target <= upd_target.
  - Hit on upd_pc, upd_taken=0: ctr saturating decrement, min 2'b00; target unchanged.
  - Miss and upd_taken=1: allocate/replace entry: valid=1, tag=tag(upd_pc), target=upd_target, ctr=2'b10.
  - Miss and upd_taken=0: no table change.
  - stat_branches increments by 1, wrapping at 2^32.
- Resolution (combinational from upd_* inputs; forced 0 when upd_valid=0):
  - correct_pc = upd_taken ? upd_target : upd_pc+4.
  - redirect_valid = upd_valid && (upd_pred_taken!=upd_taken || upd_pred_target!=correct_pc).
  - redirect_pc = correct_pc; value is don't-care when redirect_valid=0 but must still equal correct_pc.
  - stat_mispredicts increments on the same edge whenever redirect_valid=1; wraps.
- Simultaneous lookup and update to the same index: lookup returns pre-update contents (no bypass). The new value is visible from the cycle after the edge.
- The update path never stalls; one update per cycle is accepted unconditionally.
- No X propagation: outputs are defined for every input once out of reset.

Test Plan:
- Reset, then pred_pc=0x100 → pred_taken=0, pred_target=0x104; stats both 0.
- Update upd_pc=0x100, taken=1, target=0x40, pred_taken=0, pred_target=0x104 → redirect_valid=1, redirect_pc=0x40, stat_mispredicts=1. Next cycle, pred_pc=0x100 → pred_taken=1, pred_target=0x40.
- Counter saturation: 3 taken updates at 0x100 (ctr reaches 11), then 1 not-taken → still predicts taken. 2nd not-taken (ctr 01) → pred_taken=0, pred_target=0x104. 3rd not-taken holds ctr=00.
- Aliasing: train 0x100 taken, then update 0x200+(64<<2)... use 0x200 with the same index (0x100+256=0x200), taken, target 0x80 → entry replaced. pred_pc=0x100 misses (0x104); pred_pc=0x200 → 0x80.
- Correct prediction: upd_taken=1, upd_target=0x40, upd_pred_taken=1, upd_pred_target=0x40 → redirect_valid=0; stat_branches increments, stat_mispredicts unchanged. Wrong target only (pred_target 0x44) → redirect_valid=1, redirect_pc=0x40.
- Async reset asserted mid-training between edges → outputs revert immediately; after release, pred_pc=0x100 → not taken, stats 0. Also: same-cycle lookup and update at 0x100 returns the old prediction.
